// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, RAM handshake state and arbiter grant states.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Saturating increment of the consecutive-data-grant counter.
  function automatic logic [3:0] streak_inc(input logic [3:0] streak, input logic [3:0] limit);
    logic [3:0] res;
    if (streak >= limit) begin
      res = limit;
    end else begin
      res = streak + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request-side and RAM-side signals of the unified memory arbiter.
interface mem_arbiter_if #(parameter int WORD_W = 32);
  import cpu_types_pkg::*;

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport req (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iwait, iload, dwait, dload
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_pick.sv
// Next-grant selector: data first unless fetch is waiting and the data streak is exhausted.
module arb_pick
  import cpu_types_pkg::*;
(
  input  logic       dreq,
  input  logic       iREN,
  input  logic [3:0] streak,
  input  logic [3:0] max_dstreak,
  output arb_state_t pick
);

  // Priority decision between the two requesters.
  always_comb begin
    pick = IDLE;
    if (dreq && !(iREN && (streak == max_dstreak))) begin
      pick = DGRANT;
    end else if (iREN) begin
      pick = IGRANT;
    end else begin
      pick = IDLE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, one transaction at a time.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4
)
(
  input logic         CLK,
  input logic         nRST,
  mem_arbiter_if.arb  bus
);

  localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

  arb_state_t state_r;
  arb_state_t next_state_s;
  arb_state_t pick_s;
  logic [3:0] streak_r;
  logic [3:0] streak_next_s;
  logic       dreq_s;
  logic       access_s;

  assign dreq_s   = bus.dREN | bus.dWEN;
  assign access_s = (bus.ramstate == ACCESS);

  // Streak update on completion; the selector sees the post-completion value.
  always_comb begin
    streak_next_s = streak_r;
    case (state_r)
      IGRANT: begin
        if (bus.iREN && access_s) begin
          streak_next_s = 4'd0;
        end else begin
          streak_next_s = streak_r;
        end
      end
      DGRANT: begin
        if (dreq_s && access_s) begin
          if (bus.iREN) begin
            streak_next_s = streak_inc(streak_r, MAX_S);
          end else begin
            streak_next_s = 4'd0;
          end
        end else begin
          streak_next_s = streak_r;
        end
      end
      default: streak_next_s = streak_r;
    endcase
  end

  arb_pick u_pick (
    .dreq        (dreq_s),
    .iREN        (bus.iREN),
    .streak      (streak_next_s),
    .max_dstreak (MAX_S),
    .pick        (pick_s)
  );

  // Next state and all outputs; RAM enables follow the live request so a drop releases the RAM at once.
  always_comb begin
    next_state_s = state_r;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = {WORD_W{1'b0}};
    bus.ramstore = {WORD_W{1'b0}};
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq_s;
    bus.iload    = {WORD_W{1'b0}};
    bus.dload    = {WORD_W{1'b0}};
    case (state_r)
      IDLE: begin
        next_state_s = pick_s;
      end
      IGRANT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          next_state_s = IDLE;
        end else if (access_s) begin
          bus.iwait    = 1'b0;
          bus.iload    = bus.ramload;
          next_state_s = pick_s;
        end else begin
          next_state_s = IGRANT;
        end
      end
      DGRANT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!dreq_s) begin
          next_state_s = IDLE;
        end else if (access_s) begin
          bus.dwait    = 1'b0;
          bus.dload    = bus.dWEN ? {WORD_W{1'b0}} : bus.ramload;
          next_state_s = pick_s;
        end else begin
          next_state_s = DGRANT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Grant state and streak registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= IDLE;
      streak_r <= 4'd0;
    end else begin
      state_r  <= next_state_s;
      streak_r <= streak_next_s;
    end
  end

endmodule
